// File: rtl/ddr_output_pkg.sv
// Width helpers shared by the DDR output gearbox and its bench.
// Pure functions only; no state, no latency, no flow control.
package ddr_output_pkg;

  // Bits in one input word: 2*RATIO beats of WIDTH pins.
  function automatic int word_width(input int width, input int ratio);
    return width * 2 * ratio;
  endfunction

  // Phase counter width, never below one bit so RATIO=1 still builds.
  function automatic int phase_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ddr_oddr_lane.sv
// One-pin DDR output register: d1 on the high phase, d2 on the low phase.
// Latency one clk edge; no flow control. XILINX_7SERIES selects the ODDR primitive.
module ddr_oddr_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic d1,
  input  logic d2,
  output logic q
);

`ifdef XILINX_7SERIES
  ODDR #(
    .DDR_CLK_EDGE("SAME_EDGE"),
    .INIT        (1'b0),
    .SRTYPE      ("ASYNC")
  ) u_oddr (
    .Q (q),
    .C (clk),
    .CE(1'b1),
    .D1(d1),
    .D2(d2),
    .R (~rst_n),
    .S (1'b0)
  );
`else
  logic d1_q;
  logic d2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_q <= 1'b0;
      d2_q <= 1'b0;
    end else begin
      d1_q <= d1;
      d2_q <= d2;
    end
  end

  assign q = clk ? d1_q : d2_q;
`endif

endmodule

// File: rtl/ddr_output_gearbox.sv
// Parallel-to-DDR gearbox: FIFO-buffered words serialised two beats per clk. Optional DDR_OUT_TRAIN_EN.
// Latency: accept at edge N -> beats 0/1 on dout in the cycle after N+2; s_ready = !full, no push-on-pop when full.
module ddr_output_gearbox
  import ddr_output_pkg::*;
#(
  parameter int              WIDTH      = 16,
  parameter int              RATIO      = 4,
  parameter int              DEPTH      = 4,
  parameter logic [WIDTH-1:0] IDLE_VALUE = '0
) (
  input  logic                                clk,
  input  logic                                rst_n,
`ifdef DDR_OUT_TRAIN_EN
  input  logic                                train_en,
`endif
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [word_width(WIDTH, RATIO)-1:0] s_data,
  output logic                                busy,
  output logic                                underrun,
  output logic [WIDTH-1:0]                    dout
);

  localparam int WW    = word_width(WIDTH, RATIO);
  localparam int PH_W  = phase_width(RATIO);
  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [WW-1:0] word_t;

  word_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             out_en;
  word_t            shreg;
  logic [PH_W-1:0]  phase;
  logic             active;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             last_beat;
  logic             boundary;
  logic             train;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;

`ifdef DDR_OUT_TRAIN_EN
  assign train = train_en;
`else
  assign train = 1'b0;
`endif

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign s_ready   = out_en & ~full;
  assign push      = s_valid & s_ready;
  assign last_beat = (phase == PH_W'(RATIO - 1));
  assign boundary  = ~active | last_beat;
  // Training parks the queue at word boundaries, so an in-flight word always finishes first.
  assign pop       = boundary & ~empty & ~train;
  assign busy      = active | ~empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      shreg    <= '0;
      phase    <= '0;
      active   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      out_en   <= 1'b1;
      underrun <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (pop) begin
        shreg  <= mem[rd_ptr];
        phase  <= '0;
        active <= 1'b1;
      end else if (active) begin
        shreg <= shreg >> (2 * WIDTH);
        phase <= phase + 1'b1;
        if (last_beat) begin
          // Not popping here means the FIFO ran dry, unless training is holding it.
          active   <= 1'b0;
          phase    <= '0;
          underrun <= ~train;
        end
      end
    end
  end

  always_comb begin
    d1 = IDLE_VALUE;
    d2 = IDLE_VALUE;
    if (active) begin
      d1 = shreg[WIDTH-1:0];
      d2 = shreg[2*WIDTH-1:WIDTH];
    end else if (train) begin
      d1 = '1;
      d2 = '0;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ddr_oddr_lane u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .d1   (d1[i]),
      .d2   (d2[i]),
      .q    (dout[i])
    );
  end

endmodule

// File: tb/tb_ddr_output_gearbox.sv
// Scoreboard bench for ddr_output_gearbox at WIDTH=4, RATIO=2, DEPTH=4.
// A second instance with IDLE_VALUE=4'h9 covers the idle level.
module tb_ddr_output_gearbox;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        busy;
  logic        underrun;
  logic [3:0]  dout;
  logic        s_ready2;
  logic        busy2;
  logic        underrun2;
  logic [3:0]  dout2;
`ifdef DDR_OUT_TRAIN_EN
  logic        train_en = 1'b0;
  logic        train_en2 = 1'b0;
`endif

  always #5 clk = ~clk;

  ddr_output_gearbox #(.WIDTH(4), .RATIO(2), .DEPTH(4), .IDLE_VALUE(4'h0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef DDR_OUT_TRAIN_EN
    .train_en(train_en),
`endif
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .busy    (busy),
    .underrun(underrun),
    .dout    (dout)
  );

  ddr_output_gearbox #(.WIDTH(4), .RATIO(2), .DEPTH(4), .IDLE_VALUE(4'h9)) dut_idle (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef DDR_OUT_TRAIN_EN
    .train_en(train_en2),
`endif
    .s_valid (1'b0),
    .s_ready (s_ready2),
    .s_data  (16'h0000),
    .busy    (busy2),
    .underrun(underrun2),
    .dout    (dout2)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [7:0]  exp_q[$];
  int          first_edge = -1;
  int          last_edge = -1;
  int          urun_cnt = 0;
  int          train_pairs = 0;
  bit          mon_train = 1'b0;
  int          acc_total = 0;
  int          stall_cnt = 0;
  int          first_stall_at = -1;
  logic [3:0]  mon_r;
  logic [3:0]  mon_f;
  logic [7:0]  mon_x;
  int          mon_e;

  always @(posedge clk) cyc++;

  // Monitor: one {rise,fall} pair per cycle; anything other than idle must match the scoreboard.
  always begin
    @(posedge clk);
    #2;
    mon_e = cyc;
    mon_r = dout;
    if (underrun === 1'b1) urun_cnt++;
    @(negedge clk);
    #2;
    mon_f = dout;
    if ({mon_r, mon_f} !== 8'h00) begin
      if (mon_train && {mon_r, mon_f} === 8'hF0) begin
        train_pairs++;
      end else if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got %h/%h at edge %0d, required idle 0/0", mon_r, mon_f, mon_e);
      end else begin
        mon_x = exp_q.pop_front();
        n_tests++;
        if ({mon_r, mon_f} !== mon_x) begin
          n_fail++;
          $display("FAIL beat_pair: got %h/%h at edge %0d, required %h/%h",
                   mon_r, mon_f, mon_e, mon_x[7:4], mon_x[3:0]);
        end
        if (first_edge < 0) first_edge = mon_e;
        last_edge = mon_e;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge, s_valid left high.
  task automatic push_word(input logic [15:0] w, input bit track, output int edge_n);
    int budget;
    bit acc;
    budget = 50;
    edge_n = -1;
    if (track) begin
      exp_q.push_back({w[3:0], w[7:4]});
      exp_q.push_back({w[11:8], w[15:12]});
    end
    s_data  = w;
    s_valid = 1'b1;
    while (budget > 0) begin
      acc = s_ready;
      @(posedge clk);
      #1;
      budget--;
      if (acc) begin
        edge_n = cyc;
        acc_total++;
        break;
      end
      stall_cnt++;
      if (first_stall_at < 0) first_stall_at = acc_total;
    end
    n_tests++;
    if (edge_n < 0) begin
      n_fail++;
      $display("FAIL push_timeout: word %h not accepted, required accept within 50 cycles", w);
    end
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 60;
    while (budget > 0 && !(exp_q.size() == 0 && busy === 1'b0)) begin
      @(posedge clk);
      #1;
      budget--;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d pairs pending busy=%b, required 0 pending busy=0", name, exp_q.size(), busy);
    end
  endtask

  task automatic clear_stats();
    first_edge = -1;
    last_edge = -1;
    urun_cnt = 0;
    acc_total = 0;
    stall_cnt = 0;
    first_stall_at = -1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    #2;
    n_tests++;
    if ({s_ready, busy, underrun, dout} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: s_ready=%b busy=%b underrun=%b dout=%h, required all 0",
               s_ready, busy, underrun, dout);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (s_ready !== 1'b1 || busy !== 1'b0 || dout !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_release: s_ready=%b busy=%b dout=%h, required 1/0/0", s_ready, busy, dout);
    end
    n_tests++;
    if (dout2 !== 4'h9) begin
      n_fail++;
      $display("FAIL reset_release_idle: dout2=%h, required 9", dout2);
    end
  endtask

  task automatic test_single();
    int n;
    clear_stats();
    push_word(16'hA5C3, 1'b1, n);
    s_valid = 1'b0;
    wait_drain("single");
    n_tests++;
    if (first_edge != n + 2 || last_edge != n + 3) begin
      n_fail++;
      $display("FAIL single_latency: beats at edges %0d..%0d, required %0d..%0d", first_edge, last_edge, n + 2, n + 3);
    end
    n_tests++;
    if (urun_cnt != 1) begin
      n_fail++;
      $display("FAIL single_underrun: %0d pulses, required 1", urun_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_stats();
    push_word(16'h1111, 1'b1, n);
    push_word(16'h2222, 1'b1, n);
    push_word(16'h3333, 1'b1, n);
    s_valid = 1'b0;
    wait_drain("b2b");
    n_tests++;
    if (last_edge - first_edge != 5) begin
      n_fail++;
      $display("FAIL b2b_gapless: 6 pairs span %0d edges, required 5", last_edge - first_edge);
    end
    n_tests++;
    if (urun_cnt != 1) begin
      n_fail++;
      $display("FAIL b2b_underrun: %0d pulses, required 1", urun_cnt);
    end
  endtask

  task automatic test_full();
    int n;
    logic [15:0] w;
    clear_stats();
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) w[j*4 +: 4] = 4'(((k * 4 + j) % 15) + 1);
      push_word(w, 1'b1, n);
    end
    s_valid = 1'b0;
    wait_drain("full");
    n_tests++;
    if (first_stall_at != 7 || stall_cnt != 1) begin
      n_fail++;
      $display("FAIL full_ready: stall after %0d accepts, %0d stall cycles, required 7 and 1",
               first_stall_at, stall_cnt);
    end
    n_tests++;
    if (last_edge - first_edge != 15 || urun_cnt != 1) begin
      n_fail++;
      $display("FAIL full_stream: span %0d underruns %0d, required 15 and 1", last_edge - first_edge, urun_cnt);
    end
  endtask

  task automatic test_idle_value();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      n_tests++;
      if (dout2 !== 4'h9 || busy2 !== 1'b0 || underrun2 !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_rise: cycle %0d dout2=%h busy2=%b underrun2=%b, required 9/0/0", i, dout2, busy2, underrun2);
      end
      @(negedge clk);
      #2;
      n_tests++;
      if (dout2 !== 4'h9) begin
        n_fail++;
        $display("FAIL idle_fall: cycle %0d dout2=%h, required 9", i, dout2);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_word();
    int n;
    clear_stats();
    push_word(16'h7E5B, 1'b0, n);
    s_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (dout !== 4'hB) begin
      n_fail++;
      $display("FAIL midword_started: dout=%h, required B", dout);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (dout !== 4'h0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midword_reset: dout=%h s_ready=%b, required 0/0", dout, s_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (busy !== 1'b0 || dout !== 4'h0 || s_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL midword_after: cycle %0d busy=%b dout=%h s_ready=%b, required 0/0/1", i, busy, dout, s_ready);
      end
    end
  endtask

`ifdef DDR_OUT_TRAIN_EN
  task automatic test_train();
    int n;
    int t;
    clear_stats();
    train_pairs = 0;
    mon_train   = 1'b1;
    train_en    = 1'b1;
    push_word(16'h4321, 1'b1, n);
    push_word(16'h8765, 1'b1, n);
    s_valid = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (busy !== 1'b1 || exp_q.size() != 4 || urun_cnt != 0 || train_pairs < 6) begin
      n_fail++;
      $display("FAIL train_hold: busy=%b pending=%0d underruns=%0d pattern=%0d, required 1/4/0/>=6",
               busy, exp_q.size(), urun_cnt, train_pairs);
    end
    train_en = 1'b0;
    t = cyc;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    mon_train = 1'b0;
    wait_drain("train");
    n_tests++;
    if (first_edge != t + 2 || last_edge - first_edge != 3) begin
      n_fail++;
      $display("FAIL train_resume: beats at %0d..%0d, required %0d..%0d", first_edge, last_edge, t + 2, t + 5);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_idle_value();
    test_reset_mid_word();
`ifdef DDR_OUT_TRAIN_EN
    test_train();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
